div_seq_ctrl: RTL and testbench

// Sequencer for RV32M DIV/DIVU/REM/REMU. It drives a single n_bit_add_sub instance through a

---
 rtl/div_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_div_seq_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - RV32M DIV/DIVU/REM/REMU sequencer over one shared add/sub unit
// Restoring division, one quotient bit per cycle, sign fix-up on the same adder.

module n_bit_add_sub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         m,
  output logic [N-1:0] sum
);
  // m=1 turns the adder into a - b via two's complement of b
  assign sum = a + (b ^ {N{m}}) + {{(N-1){1'b0}}, m};
endmodule

module div_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem, dvd, dvs;
  logic            is_rem, neg_q, neg_r;

  logic [XLEN:0]   add_a, add_b, add_sum;
  logic            add_m;
  logic            accept, is_signed, div_zero, ovf, special, borrow, negate;
  logic [XLEN-1:0] special_val, fix_sel, op1_abs, op2_abs;

  n_bit_add_sub #(.N(XLEN + 1)) u_add_sub (
    .a   (add_a),
    .b   (add_b),
    .m   (add_m),
    .sum (add_sum)
  );

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign accept      = in_ready && in_valid;
  assign is_signed   = !op[0];
  assign div_zero    = (op2 == '0);
  assign ovf         = is_signed && (op1 == INT_MIN) && (op2 == '1);
  assign special     = div_zero || ovf;
  assign special_val = op[1] ? (div_zero ? op1 : '0) : (div_zero ? '1 : op1);
  assign op1_abs     = (is_signed && op1[XLEN-1]) ? -op1 : op1;
  assign op2_abs     = (is_signed && op2[XLEN-1]) ? -op2 : op2;

  // Trial subtraction runs one bit wider so the shifted-out remainder MSB is kept
  assign borrow  = add_sum[XLEN];
  assign fix_sel = is_rem ? rem : dvd;
  assign negate  = is_rem ? neg_r : neg_q;

  always_comb begin
    state_next = state;
    add_a      = '0;
    add_b      = '0;
    add_m      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = special ? DONE : CALC;
      end
      CALC: begin
        add_a = {rem, dvd[XLEN-1]};
        add_b = {1'b0, dvs};
        add_m = 1'b1;
        if (cnt == LAST_CNT) state_next = FIX;
      end
      FIX: begin
        add_b      = {1'b0, fix_sel};
        add_m      = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_next;
      if (kill) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              is_rem <= op[1];
              neg_q  <= is_signed && (op1[XLEN-1] ^ op2[XLEN-1]);
              neg_r  <= is_signed && op1[XLEN-1];
              cnt    <= '0;
              rem    <= '0;
              dvd    <= op1_abs;
              dvs    <= op2_abs;
              if (special) result <= special_val;
            end
          end
          CALC: begin
            rem <= borrow ? {rem[XLEN-2:0], dvd[XLEN-1]} : add_sum[XLEN-1:0];
            dvd <= {dvd[XLEN-2:0], !borrow};
            cnt <= cnt + CW'(1);
          end
          FIX: begin
            result <= negate ? add_sum[XLEN-1:0] : fix_sel;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - directed self-checking bench for div_seq_ctrl
// Latency counts cycles after the accept cycle: 1 = out_valid right after the accept edge.

module tb_div_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset, in_valid, kill, out_ready;
  logic        in_ready, out_valid, busy;
  logic [1:0]  op;
  logic [31:0] op1, op2, result;
  int          checks = 0;
  int          errors = 0;

  div_seq_ctrl #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic ack, output int lat, output logic [31:0] res);
    op = o; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] res;
    run_op(2'b00, 32'd100, 32'd7, 1'b1, lat, res);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL div_100_7 got %h exp %h", res, 32'd14); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency got %0d exp 34", lat); end
    run_op(2'b10, 32'd100, 32'd7, 1'b1, lat, res);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL rem_100_7 got %h exp %h", res, 32'd2); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL rem_latency got %0d exp 34", lat); end
  endtask

  task automatic test_signed();
    int lat; logic [31:0] res;
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1, lat, res);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got %h exp FFFFFFFD", res); end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, lat, res);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 got %h exp FFFFFFFF", res); end
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 1'b1, lat, res);
    checks++; if (res !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_big_2 got %h exp 7FFFFFFC", res); end
    run_op(2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, lat, res);
    checks++; if (res !== 32'hFFFF_FFF9) begin errors++; $display("FAIL remu_big_big got %h exp FFFFFFF9", res); end
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 1'b1, lat, res);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL rem_100_m7 got %h exp 2", res); end
  endtask

  task automatic test_special();
    int lat; logic [31:0] res;
    run_op(2'b00, 32'd5, 32'd0, 1'b1, lat, res);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero got %h exp FFFFFFFF", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div_by_zero_latency got %0d exp 1", lat); end
    run_op(2'b11, 32'd5, 32'd0, 1'b1, lat, res);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL remu_by_zero got %h exp 5", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL remu_by_zero_latency got %0d exp 1", lat); end
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow got %h exp 80000000", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div_overflow_latency got %0d exp 1", lat); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL rem_overflow got %h exp 0", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL rem_overflow_latency got %0d exp 1", lat); end
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL divu_no_overflow got %h exp 0", res); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL divu_no_overflow_latency got %0d exp 34", lat); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; int n;
    run_op(2'b00, 32'd100, 32'd7, 1'b0, lat, res);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b r=%h rdy=%b exp v=1 r=0000000e rdy=0", i, out_valid, result, in_ready);
      end
    end
    op = 2'b01; op1 = 32'd9; op2 = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_handshake got v=%b busy=%b rdy=%b exp v=0 busy=0 rdy=1", out_valid, busy, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept busy got %b exp 1", busy); end
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (result !== 32'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_result got %h v=%b exp 00000003 v=1", result, out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_kill();
    int lat; logic [31:0] res; logic seen;
    op = 2'b00; op1 = 32'd100; op2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL kill_idle got busy=%b rdy=%b v=%b exp busy=0 rdy=1 v=0", busy, in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL kill_no_valid got %b exp 0", seen); end
    run_op(2'b01, 32'd1000, 32'd10, 1'b1, lat, res);
    checks++; if (res !== 32'd100) begin errors++; $display("FAIL divu_after_kill got %h exp 00000064", res); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL divu_after_kill_latency got %0d exp 34", lat); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res;
    op = 2'b00; op1 = 32'd100; op2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 32'h0) begin
      errors++; $display("FAIL reset_mid got busy=%b v=%b rdy=%b r=%h exp busy=0 v=0 rdy=0 r=00000000", busy, out_valid, in_ready, result);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_release got %b exp 1", in_ready); end
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 1'b1, lat, res);
    checks++; if (res !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_m100_7 got %h exp FFFFFFF2", res); end
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 1'b1, lat, res);
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rem_m100_7 got %h exp FFFFFFFE", res); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    op = 2'b00; op1 = 32'h0; op2 = 32'h0;
    test_reset();
    test_basic();
    test_signed();
    test_special();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
